// File: rtl/pbs_ctrl.sv
// Battle-turn sequencer: the player attacks, then the AI, with a win/loss check after each.
// Drives the datapath strobes and reports turn count, busy and game-over status.
module pbs_ctrl #(
    parameter int unsigned CALC_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TURN_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_valid,
    input  logic [1:0]        move_sel,
    input  logic [3:0]        p_hp,
    input  logic [3:0]        AI_hp,
    output logic              target,
    output logic [1:0]        p_move,
    output logic              actr,
    output logic              calc_dmg,
    output logic              app_dmg,
    output logic              busy,
    output logic [TURN_W-1:0] turn_cnt,
    output logic              p_win,
    output logic              ai_win
);

    typedef enum logic [3:0] {
        IDLE, P_SEL, P_LOAD, P_CALC, P_SETTLE, P_CHECK,
        A_SEL, A_LOAD, A_CALC, A_SETTLE, A_CHECK, GAME_OVER
    } state_t;

    localparam logic [3:0] CALC_LD   = 4'(CALC_CYCLES - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              target_q, actr_q, calc_q, app_q, busy_q, p_win_q, ai_win_q;
    logic [1:0]        p_move_q;
    logic [TURN_W-1:0] turn_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:      if (move_valid) state_d = P_SEL;
            P_SEL:     state_d = P_LOAD;
            P_LOAD:    begin state_d = P_CALC; cnt_d = CALC_LD; end
            P_CALC:    if (cnt_q == 4'd0) begin
                           state_d = P_SETTLE;
                           cnt_d   = SETTLE_LD;
                       end else cnt_d = cnt_q - 4'd1;
            P_SETTLE:  if (cnt_q == 4'd0) state_d = P_CHECK;
                       else cnt_d = cnt_q - 4'd1;
            // Only the side just attacked is examined.
            P_CHECK:   state_d = (AI_hp == 4'd0) ? GAME_OVER : A_SEL;
            A_SEL:     state_d = A_LOAD;
            A_LOAD:    begin state_d = A_CALC; cnt_d = CALC_LD; end
            A_CALC:    if (cnt_q == 4'd0) begin
                           state_d = A_SETTLE;
                           cnt_d   = SETTLE_LD;
                       end else cnt_d = cnt_q - 4'd1;
            A_SETTLE:  if (cnt_q == 4'd0) state_d = A_CHECK;
                       else cnt_d = cnt_q - 4'd1;
            A_CHECK:   state_d = (p_hp == 4'd0) ? GAME_OVER : IDLE;
            GAME_OVER: state_d = GAME_OVER;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= 1'b0;
            actr_q   <= 1'b0;
            calc_q   <= 1'b0;
            app_q    <= 1'b0;
            busy_q   <= 1'b0;
            p_win_q  <= 1'b0;
            ai_win_q <= 1'b0;
            p_move_q <= '0;
            turn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && move_valid)
                p_move_q <= move_sel;
            calc_q <= (state_d == P_CALC) || (state_d == A_CALC);
            app_q  <= (state_d == P_LOAD) || (state_d == A_LOAD);
            busy_q <= !((state_d == IDLE) || (state_d == GAME_OVER));
            // target/actr are held outside the attack phases so they never glitch.
            if (state_d inside {P_SEL, P_LOAD, P_CALC, P_SETTLE, P_CHECK}) begin
                target_q <= 1'b1;
                actr_q   <= 1'b0;
            end else if (state_d inside {A_SEL, A_LOAD, A_CALC, A_SETTLE, A_CHECK}) begin
                target_q <= 1'b0;
                actr_q   <= 1'b1;
            end
            if (state_q == A_CHECK && state_d == IDLE && turn_q != '1)
                turn_q <= turn_q + TURN_W'(1);
            if (state_q == P_CHECK && state_d == GAME_OVER)
                p_win_q <= 1'b1;
            if (state_q == A_CHECK && state_d == GAME_OVER)
                ai_win_q <= 1'b1;
        end
    end

    assign target   = target_q;
    assign actr     = actr_q;
    assign calc_dmg = calc_q;
    assign app_dmg  = app_q;
    assign busy     = busy_q;
    assign p_move   = p_move_q;
    assign turn_cnt = turn_q;
    assign p_win    = p_win_q;
    assign ai_win   = ai_win_q;

endmodule
